// File: rtl/fdivsqrt_issue_ctrl.sv
// Issue sequencer and round-robin arbiter in front of the shared recFN32 divide/sqrt unit.
// Keeps a single op in flight, holds its result until writeback accepts it, and supports flush.
module fdivsqrt_issue_ctrl #(
    parameter int unsigned TAG_W   = 5,
    parameter int unsigned RR_INIT = 0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [1:0]           req_valid,
    output logic [1:0]           req_ready,
    input  logic [1:0]           req_sqrt,
    input  logic [65:0]          req_a,
    input  logic [65:0]          req_b,
    input  logic [5:0]           req_rm,
    input  logic [2*TAG_W-1:0]   req_tag,
    input  logic                 du_inReady,
    output logic                 du_inValid,
    output logic                 du_sqrtOp,
    output logic [32:0]          du_a,
    output logic [32:0]          du_b,
    output logic [2:0]           du_roundingMode,
    input  logic                 du_outValid_div,
    input  logic                 du_outValid_sqrt,
    input  logic [32:0]          du_out,
    input  logic [4:0]           du_exceptionFlags,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic                 resp_src,
    output logic [TAG_W-1:0]     resp_tag,
    output logic [32:0]          resp_data,
    output logic [4:0]           resp_flags,
    input  logic                 flush,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, BUSY, DRAIN, HOLD} state_t;

    state_t           state;
    logic             rrPtr;
    logic             opSqrt;
    logic             opSrc;
    logic [TAG_W-1:0] opTag;
    logic             grant;
    logic             issue;
    logic             complete;
    logic [TAG_W-1:0] grantTag;

    // Round-robin pointer only matters when both requesters compete.
    always_comb begin
        grant = (&req_valid) ? rrPtr : req_valid[1];
    end

    assign du_inValid      = ~reset & (state == IDLE) & (|req_valid) & ~flush;
    assign issue           = du_inValid & du_inReady;
    assign req_ready       = issue ? (grant ? 2'b10 : 2'b01) : 2'b00;
    assign du_sqrtOp       = grant ? req_sqrt[1] : req_sqrt[0];
    assign du_a            = grant ? req_a[65:33] : req_a[32:0];
    assign du_b            = grant ? req_b[65:33] : req_b[32:0];
    assign du_roundingMode = grant ? req_rm[5:3] : req_rm[2:0];
    assign grantTag        = grant ? req_tag[2*TAG_W-1:TAG_W] : req_tag[TAG_W-1:0];
    assign complete        = opSqrt ? du_outValid_sqrt : du_outValid_div;
    assign busy            = (state != IDLE);

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            rrPtr      <= 1'(RR_INIT);
            opSqrt     <= 1'b0;
            opSrc      <= 1'b0;
            opTag      <= '0;
            resp_valid <= 1'b0;
            resp_src   <= 1'b0;
            resp_tag   <= '0;
            resp_data  <= '0;
            resp_flags <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        state  <= BUSY;
                        opSqrt <= du_sqrtOp;
                        opSrc  <= grant;
                        opTag  <= grantTag;
                        rrPtr  <= ~grant;
                    end
                end
                BUSY: begin
                    if (flush) begin
                        // A completion coinciding with flush is simply discarded.
                        state <= complete ? IDLE : DRAIN;
                    end else if (complete) begin
                        state      <= HOLD;
                        resp_valid <= 1'b1;
                        resp_src   <= opSrc;
                        resp_tag   <= opTag;
                        resp_data  <= du_out;
                        resp_flags <= du_exceptionFlags;
                    end
                end
                DRAIN: begin
                    if (complete) begin
                        state <= IDLE;
                    end
                end
                HOLD: begin
                    // Flush takes precedence over a simultaneous writeback accept.
                    if (flush || resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fdivsqrt_issue_ctrl.sv
// Directed self-checking bench for fdivsqrt_issue_ctrl; the unit's completion pulses are driven by hand.
module tb_fdivsqrt_issue_ctrl;
    localparam int unsigned TAG_W = 5;

    logic               clock = 1'b0;
    logic               reset;
    logic [1:0]         req_valid;
    logic [1:0]         req_ready;
    logic [1:0]         req_sqrt;
    logic [65:0]        req_a;
    logic [65:0]        req_b;
    logic [5:0]         req_rm;
    logic [2*TAG_W-1:0] req_tag;
    logic               du_inReady;
    logic               du_inValid;
    logic               du_sqrtOp;
    logic [32:0]        du_a;
    logic [32:0]        du_b;
    logic [2:0]         du_roundingMode;
    logic               du_outValid_div;
    logic               du_outValid_sqrt;
    logic [32:0]        du_out;
    logic [4:0]         du_exceptionFlags;
    logic               resp_valid;
    logic               resp_ready;
    logic               resp_src;
    logic [TAG_W-1:0]   resp_tag;
    logic [32:0]        resp_data;
    logic [4:0]         resp_flags;
    logic               flush;
    logic               busy;

    int evaluated = 0;
    int failures  = 0;

    localparam logic [32:0] A1 = 33'h0_40000000;
    localparam logic [32:0] B1 = 33'h0_3F800000;
    localparam logic [32:0] A2 = 33'h0_41200000;
    localparam logic [32:0] B2 = 33'h0_40400000;

    fdivsqrt_issue_ctrl #(.TAG_W(TAG_W), .RR_INIT(0)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_sqrt(req_sqrt),
        .req_a(req_a), .req_b(req_b), .req_rm(req_rm), .req_tag(req_tag),
        .du_inReady(du_inReady), .du_inValid(du_inValid), .du_sqrtOp(du_sqrtOp),
        .du_a(du_a), .du_b(du_b), .du_roundingMode(du_roundingMode),
        .du_outValid_div(du_outValid_div), .du_outValid_sqrt(du_outValid_sqrt),
        .du_out(du_out), .du_exceptionFlags(du_exceptionFlags),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_src(resp_src),
        .resp_tag(resp_tag), .resp_data(resp_data), .resp_flags(resp_flags),
        .flush(flush), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        evaluated++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulseDiv();
        du_outValid_div = 1'b1;
        tick();
        du_outValid_div = 1'b0;
    endtask

    task automatic pulseSqrt();
        du_outValid_sqrt = 1'b1;
        tick();
        du_outValid_sqrt = 1'b0;
    endtask

    task automatic accept();
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1; req_valid = 2'b00; req_sqrt = 2'b00;
        req_a = {A2, A1}; req_b = {B2, B1}; req_rm = {3'd4, 3'd0};
        req_tag = {5'd9, 5'd7};
        du_inReady = 1'b1; du_outValid_div = 1'b0; du_outValid_sqrt = 1'b0;
        du_out = 33'h0_3FC00000; du_exceptionFlags = 5'h01;
        resp_ready = 1'b0; flush = 1'b0;

        // Reset state; requests ignored while reset high
        tick(); tick();
        req_valid = 2'b11; #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_inValid", 64'(du_inValid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_resp_valid", 64'(resp_valid), 64'd0);
        chk("rst_resp_data", 64'(resp_data), 64'd0);
        req_valid = 2'b00;
        tick();
        reset = 1'b0;
        tick();

        // Single div from req0
        req_valid = 2'b01; #1;
        chk("t1_inValid", 64'(du_inValid), 64'd1);
        chk("t1_req_ready", 64'(req_ready), 64'd1);
        chk("t1_du_a", 64'(du_a), 64'(A1));
        chk("t1_du_b", 64'(du_b), 64'(B1));
        chk("t1_sqrtOp", 64'(du_sqrtOp), 64'd0);
        chk("t1_rm", 64'(du_roundingMode), 64'd0);
        tick();
        req_valid = 2'b11; #1;
        chk("t1_busy", 64'(busy), 64'd1);
        chk("t1_no_ready_busy", 64'(req_ready), 64'd0);
        chk("t1_no_inValid_busy", 64'(du_inValid), 64'd0);
        req_valid = 2'b00;
        for (int i = 0; i < 9; i++) tick();
        chk("t1_no_early_resp", 64'(resp_valid), 64'd0);
        pulseDiv();
        chk("t1_resp_valid", 64'(resp_valid), 64'd1);
        chk("t1_resp_src", 64'(resp_src), 64'd0);
        chk("t1_resp_tag", 64'(resp_tag), 64'd7);
        chk("t1_resp_data", 64'(resp_data), 64'h0_3FC00000);
        chk("t1_resp_flags", 64'(resp_flags), 64'h01);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t1_hold_valid", 64'(resp_valid), 64'd1);
            chk("t1_hold_data", 64'(resp_data), 64'h0_3FC00000);
        end
        accept();
        chk("t1_after_wb_valid", 64'(resp_valid), 64'd0);
        chk("t1_after_wb_busy", 64'(busy), 64'd0);

        // Round robin with both requesters valid, fresh from reset
        reset = 1'b1; tick(); reset = 1'b0;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_req_ready", 64'(req_ready), (i % 2 == 0) ? 64'd1 : 64'd2);
            chk("rr_du_a", 64'(du_a), (i % 2 == 0) ? 64'(A1) : 64'(A2));
            tick();
            chk("rr_busy", 64'(busy), 64'd1);
            chk("rr_no_ready", 64'(req_ready), 64'd0);
            tick();
            pulseDiv();
            chk("rr_resp_src", 64'(resp_src), 64'(i % 2));
            chk("rr_resp_tag", 64'(resp_tag), (i % 2 == 0) ? 64'd7 : 64'd9);
            chk("rr_no_ready_hold", 64'(req_ready), 64'd0);
            accept();
        end
        req_valid = 2'b00;
        tick();

        // Sqrt with spurious div pulse first
        req_valid = 2'b01; req_sqrt = 2'b01; #1;
        chk("sq_sqrtOp", 64'(du_sqrtOp), 64'd1);
        tick();
        req_valid = 2'b00; req_sqrt = 2'b00;
        du_out = 33'h0_3FB504F3; du_exceptionFlags = 5'h01;
        pulseDiv();
        chk("sq_spurious_ignored", 64'(resp_valid), 64'd0);
        chk("sq_still_busy", 64'(busy), 64'd1);
        tick();
        pulseSqrt();
        chk("sq_resp_valid", 64'(resp_valid), 64'd1);
        chk("sq_resp_data", 64'(resp_data), 64'h0_3FB504F3);
        accept();

        // Flush 3 cycles after issue, req1 pending during drain
        req_valid = 2'b01; #1;
        chk("fl_issue0", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b10;
        tick(); tick();
        flush = 1'b1; tick(); flush = 1'b0; #1;
        chk("fl_drain_busy", 64'(busy), 64'd1);
        chk("fl_drain_no_ready", 64'(req_ready), 64'd0);
        tick();
        du_out = 33'h0_12345678; du_exceptionFlags = 5'h04;
        pulseDiv();
        chk("fl_no_resp", 64'(resp_valid), 64'd0);
        chk("fl_idle_inValid", 64'(du_inValid), 64'd1);
        chk("fl_req1_ready", 64'(req_ready), 64'd2);
        tick();
        req_valid = 2'b00;
        chk("fl_req1_busy", 64'(busy), 64'd1);
        pulseDiv();
        chk("fl_req1_src", 64'(resp_src), 64'd1);
        chk("fl_req1_tag", 64'(resp_tag), 64'd9);
        chk("fl_req1_flags", 64'(resp_flags), 64'h04);
        // Flush with resp_ready in HOLD
        flush = 1'b1; resp_ready = 1'b1; tick(); flush = 1'b0; resp_ready = 1'b0;
        chk("fl_hold_drop", 64'(resp_valid), 64'd0);
        chk("fl_hold_idle", 64'(busy), 64'd0);

        // Flush blocks issue in IDLE
        req_valid = 2'b01; flush = 1'b1; #1;
        chk("fi_inValid", 64'(du_inValid), 64'd0);
        chk("fi_req_ready", 64'(req_ready), 64'd0);
        flush = 1'b0; #1;
        chk("fi_inValid_released", 64'(du_inValid), 64'd1);
        tick();
        req_valid = 2'b00;
        // Flush coinciding with completion
        flush = 1'b1; du_outValid_div = 1'b1; tick();
        flush = 1'b0; du_outValid_div = 1'b0;
        chk("fc_idle", 64'(busy), 64'd0);
        chk("fc_no_resp", 64'(resp_valid), 64'd0);
        tick();
        chk("fc_no_resp_late", 64'(resp_valid), 64'd0);

        // Reset while busy
        req_valid = 2'b01; tick();
        req_valid = 2'b00;
        chk("rb_busy", 64'(busy), 64'd1);
        reset = 1'b1; req_valid = 2'b11; #1;
        chk("rb_req_ready", 64'(req_ready), 64'd0);
        chk("rb_inValid", 64'(du_inValid), 64'd0);
        tick();
        chk("rb_busy_cleared", 64'(busy), 64'd0);
        chk("rb_resp_data", 64'(resp_data), 64'd0);
        chk("rb_resp_tag", 64'(resp_tag), 64'd0);
        chk("rb_resp_flags", 64'(resp_flags), 64'd0);
        reset = 1'b0; req_valid = 2'b01; #1;
        chk("rb_resume_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        du_out = 33'h0_3F000000; du_exceptionFlags = 5'h00;
        pulseDiv();
        chk("rb_resume_resp", 64'(resp_valid), 64'd1);
        chk("rb_resume_data", 64'(resp_data), 64'h0_3F000000);
        accept();

        $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "timeout");
    end
endmodule
